// File: rtl/serial_dat_rx_if.sv
// Bundle between the serial clock/data source and the serial data receiver.
// The master drives the serial line and controls; the slave returns the assembled word.
interface serial_dat_rx_if #(
    parameter int P_W = 32
);
    logic           en;
    logic           y0;
    logic [7:0]     ncyc;
    logic [31:0]    tmo;
    logic           ck;
    logic           sdi;
    logic [P_W-1:0] dout;
    logic           valid;
    logic           busy;
    logic           err;

    modport master (
        output en, y0, ncyc, tmo, ck, sdi,
        input  dout, valid, busy, err
    );

    modport slave (
        input  en, y0, ncyc, tmo, ck, sdi,
        output dout, valid, busy, err
    );
endinterface

// File: rtl/serial_dat_rx.sv
// Serial data receiver: samples sdi on each trailing edge of ck (system-clock domain),
// assembles msb-first words and aborts stalled frames after a programmable timeout.
module serial_dat_rx #(
    parameter int P_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    serial_dat_rx_if.slave  bus
);
    typedef enum logic {S_IDLE, S_RX} state_t;

    state_t         r_state,   w_state_n;
    logic           r_ck_q;
    logic           r_y0_l,    w_y0_l_n;
    logic [7:0]     r_ncyc_l,  w_ncyc_l_n;
    logic [7:0]     r_bit_cnt, w_bit_cnt_n;
    logic [31:0]    r_tmo_cnt, w_tmo_cnt_n;
    logic [P_W-1:0] r_sr,      w_sr_n;
    logic [P_W-1:0] r_dout,    w_dout_n;
    logic           r_valid,   w_valid_n;
    logic           r_err,     w_err_n;

    logic           w_pol;
    logic           w_lead;
    logic           w_trail;
    logic [P_W-1:0] w_shift;
    logic           w_last_bit;
    logic           w_tmo_hit;

    // Polarity follows the live idle level until a frame has latched its own.
    assign w_pol      = (r_state == S_IDLE) ? bus.y0 : r_y0_l;
    assign w_lead     = (r_ck_q == w_pol)  && (bus.ck == !w_pol);
    assign w_trail    = (r_ck_q == !w_pol) && (bus.ck == w_pol);
    assign w_shift    = {r_sr[P_W-2:0], bus.sdi};
    assign w_last_bit = (r_bit_cnt == (r_ncyc_l - 8'd1));
    assign w_tmo_hit  = (r_tmo_cnt == (bus.tmo - 32'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ck_q    <= bus.y0;
            r_y0_l    <= 1'b0;
            r_ncyc_l  <= 8'd1;
            r_bit_cnt <= '0;
            r_tmo_cnt <= '0;
            r_sr      <= '0;
            r_dout    <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_ck_q    <= bus.ck;
            r_y0_l    <= w_y0_l_n;
            r_ncyc_l  <= w_ncyc_l_n;
            r_bit_cnt <= w_bit_cnt_n;
            r_tmo_cnt <= w_tmo_cnt_n;
            r_sr      <= w_sr_n;
            r_dout    <= w_dout_n;
            r_valid   <= w_valid_n;
            r_err     <= w_err_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_y0_l_n    = r_y0_l;
        w_ncyc_l_n  = r_ncyc_l;
        w_bit_cnt_n = r_bit_cnt;
        w_tmo_cnt_n = r_tmo_cnt;
        w_sr_n      = r_sr;
        w_dout_n    = r_dout;
        w_valid_n   = 1'b0;
        w_err_n     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.en && w_lead) begin
                    w_y0_l_n    = bus.y0;
                    w_ncyc_l_n  = (bus.ncyc == 8'd0) ? 8'd1 : bus.ncyc;
                    w_bit_cnt_n = '0;
                    w_tmo_cnt_n = '0;
                    w_sr_n      = '0;
                    w_state_n   = S_RX;
                end
            end
            S_RX: begin
                // Disarm wins over data and timeout alike; the frame is dropped silently.
                if (!bus.en) begin
                    w_state_n = S_IDLE;
                end else if (w_trail) begin
                    w_sr_n      = w_shift;
                    w_tmo_cnt_n = '0;
                    if (w_last_bit) begin
                        w_dout_n  = w_shift;
                        w_valid_n = 1'b1;
                        w_state_n = S_IDLE;
                    end else begin
                        w_bit_cnt_n = r_bit_cnt + 8'd1;
                    end
                end else if (bus.tmo != 32'd0) begin
                    if (w_tmo_hit) begin
                        w_err_n   = 1'b1;
                        w_state_n = S_IDLE;
                    end else begin
                        w_tmo_cnt_n = r_tmo_cnt + 32'd1;
                    end
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    assign bus.dout  = r_dout;
    assign bus.valid = r_valid;
    assign bus.err   = r_err;
    assign bus.busy  = (r_state == S_RX);
endmodule

// File: tb/tb_serial_dat_rx.sv
// Directed bench for serial_dat_rx: stimulus pushes expected pulses to a scoreboard,
// a negedge monitor pops and compares kind, word and arrival cycle.
module tb_serial_dat_rx;
    logic clk = 1'b0;
    logic rst;

    serial_dat_rx_if #(.P_W(32)) bus();
    serial_dat_rx #(.P_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [31:0] dout;
        int          at;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && (bus.valid || bus.err)) begin
            chk("valid_err_excl", 64'(bus.valid & bus.err), 64'd0);
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got valid=%0b err=%0b dout=%0h, want none (cycle %0d)",
                         bus.valid, bus.err, bus.dout, cyc);
            end else begin
                e = sbq.pop_front();
                chk("pulse_kind_err", 64'(bus.err), 64'(e.is_err));
                chk("pulse_dout", 64'(bus.dout), 64'(e.dout));
                chk("pulse_cycle", 64'(cyc), 64'(e.at));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic expect_evt(input bit is_err, input logic [31:0] d, input int at);
        exp_t e;
        e.is_err = is_err;
        e.dout   = d;
        e.at     = at;
        sbq.push_back(e);
    endtask

    // One bit: leading level for 3 clks with data launched, then the trailing level.
    task automatic bit_out(input logic b, input bit first, output int pt);
        bus.ck  = ~bus.y0;
        bus.sdi = b;
        tick();
        if (first) chk("busy_at_lead", 64'(bus.busy), 64'd1);
        repeat (2) tick();
        bus.ck = bus.y0;
        pt = cyc;
    endtask

    task automatic send_bits(input logic [63:0] d, input int msb, input logic [31:0] exp,
                             input int gap, input bit first);
        int pt;
        for (int i = msb; i >= 0; i--) begin
            bit_out(d[i], first && (i == msb), pt);
            if (i == 0) begin
                expect_evt(1'b0, exp, pt + 1);
                tick();
                chk("busy_after_valid", 64'(bus.busy), 64'd0);
                repeat (gap - 1) tick();
            end else begin
                repeat (3) tick();
            end
        end
    endtask

    task automatic send_word(input logic [63:0] d, input int n, input logic [31:0] exp,
                             input int gap);
        send_bits(d, n - 1, exp, gap, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int pt;
        rst      = 1'b1;
        bus.en   = 1'b0;
        bus.y0   = 1'b0;
        bus.ncyc = 8'd8;
        bus.tmo  = 32'd0;
        bus.ck   = 1'b0;
        bus.sdi  = 1'b0;
        repeat (3) tick();
        chk("rst_dout",  64'(bus.dout),  64'd0);
        chk("rst_valid", 64'(bus.valid), 64'd0);
        chk("rst_err",   64'(bus.err),   64'd0);
        chk("rst_busy",  64'(bus.busy),  64'd0);
        rst = 1'b0;
        tick();
        bus.en = 1'b1;
        tick();

        // Basic 8-bit frame.
        send_word(64'hA5, 8, 32'h0000_00A5, 3);

        // Inverted clock; a lone trailing edge while idle must not start a frame.
        bus.en = 1'b0; bus.y0 = 1'b1; bus.ck = 1'b1;
        repeat (2) tick();
        bus.ck = 1'b0;
        tick();
        bus.en = 1'b1; bus.ck = 1'b1;
        tick();
        chk("idle_trail_busy", 64'(bus.busy), 64'd0);
        repeat (3) tick();
        chk("idle_trail_busy2", 64'(bus.busy), 64'd0);
        send_word(64'h3C, 8, 32'h0000_003C, 3);

        // Long frame keeps the last 32 bits; ncyc=0 acts as one bit.
        bus.y0 = 1'b0; bus.ck = 1'b0;
        repeat (2) tick();
        bus.ncyc = 8'd40;
        send_word(64'h12_3456_789A, 40, 32'h3456_789A, 3);
        bus.ncyc = 8'd0;
        send_word(64'h1, 1, 32'h0000_0001, 3);

        // Stall after 3 bits: err 100 clks after the 3rd trail, dout kept.
        bus.ncyc = 8'd8;
        bus.tmo  = 32'd100;
        bit_out(1'b1, 1'b1, pt); repeat (3) tick();
        bit_out(1'b0, 1'b0, pt); repeat (3) tick();
        bit_out(1'b1, 1'b0, pt);
        expect_evt(1'b1, 32'h0000_0001, pt + 101);
        repeat (105) tick();
        chk("busy_after_tmo", 64'(bus.busy), 64'd0);
        chk("dout_after_tmo", 64'(bus.dout), 64'h1);
        send_word(64'h81, 8, 32'h0000_0081, 3);

        // A trail landing on the expiry cycle wins over the timeout.
        bit_out(1'b1, 1'b1, pt); repeat (3) tick();
        bit_out(1'b1, 1'b0, pt); repeat (3) tick();
        bit_out(1'b0, 1'b0, pt);
        wait_until(pt + 50);
        bus.ck = ~bus.y0; bus.sdi = 1'b0;
        wait_until(pt + 100);
        bus.ck = bus.y0;
        repeat (3) tick();
        chk("busy_after_late_trail", 64'(bus.busy), 64'd1);
        send_bits(64'hC3, 3, 32'h0000_00C3, 3, 1'b0);
        bus.tmo = 32'd0;

        // Disarm mid-frame, then a clean frame.
        for (int i = 0; i < 4; i++) begin
            bit_out(1'b1, i == 0, pt);
            repeat (3) tick();
        end
        bus.en = 1'b0;
        tick();
        chk("busy_after_en_drop", 64'(bus.busy), 64'd0);
        bus.en = 1'b1;
        tick();
        send_word(64'h5A, 8, 32'h0000_005A, 3);

        // Reset mid-frame, then a clean frame.
        for (int i = 0; i < 4; i++) begin
            bit_out(1'b0, i == 0, pt);
            repeat (3) tick();
        end
        rst = 1'b1;
        #1;
        chk("busy_in_rst", 64'(bus.busy), 64'd0);
        tick();
        chk("dout_in_rst", 64'(bus.dout), 64'd0);
        rst = 1'b0;
        tick();
        send_word(64'h5A, 8, 32'h0000_005A, 3);

        // Back-to-back frames, next lead on the cycle after valid.
        send_word(64'hFF, 8, 32'h0000_00FF, 1);
        send_word(64'h00, 8, 32'h0000_0000, 3);

        repeat (5) tick();
        chk("sb_pending", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
